// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and port indices for the data-memory port arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the port not granted last wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       sel
);
  always_comb begin
    gnt_valid = |req;
    sel       = &req ? ~last : (req[P1] ? P1 : P0);
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port data memory between two req/ack requesters
// with round-robin grants, registered commands and illegal-address rejection.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 2);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              legal_q, legal_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_valid, gnt_sel, grant, capture;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, cap_val;
  logic              in_access, in_resp;

  rr_arb2 u_arb (
    .req       ({p1_req_i, p0_req_i}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .sel       (gnt_sel)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      last_q   <= P1;
      sel_q    <= P0;
      we_q     <= 1'b0;
      legal_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      legal_q  <= legal_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Command fields follow the live request until the grant edge, then stay frozen.
  always_comb begin
    state_d   = (state_q == IDLE)   ? (gnt_valid ? ACCESS : IDLE) :
                (state_q == ACCESS) ? RESP : IDLE;
    grant     = (state_q == IDLE) && gnt_valid;
    cur_we    = (gnt_sel == P1) ? p1_we_i    : p0_we_i;
    cur_addr  = (gnt_sel == P1) ? p1_addr_i  : p0_addr_i;
    cur_wdata = (gnt_sel == P1) ? p1_wdata_i : p0_wdata_i;
    last_d    = grant ? gnt_sel   : last_q;
    sel_d     = grant ? gnt_sel   : sel_q;
    we_d      = grant ? cur_we    : we_q;
    addr_d    = grant ? cur_addr  : addr_q;
    wdata_d   = grant ? cur_wdata : wdata_q;
    legal_d   = grant ? (!cur_addr[0] && (cur_addr <= MAX_ADDR)) : legal_q;
    capture   = (state_q == ACCESS) && !we_q;
    cap_val   = legal_q ? mem_rdata_i : '0;
    rdata0_d  = (capture && sel_q == P0) ? cap_val : rdata0_q;
    rdata1_d  = (capture && sel_q == P1) ? cap_val : rdata1_q;
  end

  // The write strobe also depends on rst_i so a reset in ACCESS cancels the write at that edge.
  always_comb begin
    in_access   = (state_q == ACCESS);
    in_resp     = (state_q == RESP);
    mem_addr_o  = in_access ? addr_q  : '0;
    mem_wdata_o = in_access ? wdata_q : '0;
    mem_rd_o    = in_access && legal_q && !we_q;
    mem_wr_o    = in_access && legal_q && we_q && rst_i;
    p0_ack_o    = in_resp && (sel_q == P0);
    p1_ack_o    = in_resp && (sel_q == P1);
    p0_err_o    = p0_ack_o && !legal_q;
    p1_err_o    = p1_ack_o && !legal_q;
    p0_rdata_o  = rdata0_q;
    p1_rdata_o  = rdata1_q;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with per-port expectation queues checked by a monitor.
module tb_dmem_port_arbiter;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          t;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_req[2];
  logic        p_we[2];
  logic [15:0] p_addr[2];
  logic [15:0] p_wdata[2];
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem[64];
  logic [15:0] shadow[2];
  int          cyc = 0, wr_cnt = 0, rd_cnt = 0, n_cmp = 0, n_fail = 0;
  cmd_t        cq0[$], cq1[$], ex0[$], ex1[$];
  int          ack_log[$];

  dmem_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .p0_req_i    (p_req[0]),
    .p0_we_i     (p_we[0]),
    .p0_addr_i   (p_addr[0]),
    .p0_wdata_i  (p_wdata[0]),
    .p0_ack_o    (p0_ack),
    .p0_err_o    (p0_err),
    .p0_rdata_o  (p0_rdata),
    .p1_req_i    (p_req[1]),
    .p1_we_i     (p_we[1]),
    .p1_addr_i   (p_addr[1]),
    .p1_wdata_i  (p_wdata[1]),
    .p1_ack_o    (p1_ack),
    .p1_err_o    (p1_err),
    .p1_rdata_o  (p1_rdata),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_addr[6:1]] <= mem_wdata;
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
  end

  assign mem_rdata = mem[mem_addr[6:1]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ack_p(input int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  task automatic push(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic err, input logic [15:0] rd, input int lat);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.err = err; c.rdata = rd; c.lat = lat; c.t = 0;
    if (p == 0) cq0.push_back(c); else cq1.push_back(c);
  endtask

  task automatic check_ack(input int p);
    cmd_t e;
    string nm;
    if ((p == 0 ? ex0.size() : ex1.size()) == 0) begin
      chk($sformatf("unexpected_ack_p%0d", p), 1, 0);
      return;
    end
    if (p == 0) e = ex0.pop_front(); else e = ex1.pop_front();
    ack_log.push_back(p);
    nm = $sformatf("p%0d_%s_%04h", p, e.we ? "wr" : "rd", e.addr);
    chk({nm, "_err"}, (p == 0) ? p0_err : p1_err, e.err);
    chk({nm, "_rdata"}, (p == 0) ? p0_rdata : p1_rdata, e.we ? shadow[p] : e.rdata);
    if (e.lat != 0) chk({nm, "_latency"}, cyc - e.t, e.lat);
    if (!e.we) shadow[p] = e.rdata;
  endtask

  initial begin
    shadow[0] = '0;
    shadow[1] = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        shadow[0] = '0;
        shadow[1] = '0;
      end
      if (mem_rd || mem_wr) chk("strobe_exclusive", mem_rd & mem_wr, 0);
      if (p0_ack || p1_ack) chk("single_ack", p0_ack & p1_ack, 0);
      for (int p = 0; p < 2; p++) if (ack_p(p)) check_ack(p);
    end
  end

  // Requester: holds req and fields until ack; a queued command is raised straight away.
  task automatic run_port(input int p);
    cmd_t c;
    int g = 0;
    while ((p == 0 ? cq0.size() : cq1.size()) != 0 || p_req[p]) begin
      @(negedge clk);
      g++;
      if (g > 400) begin
        chk($sformatf("p%0d_ack_timeout", p), 1, 0);
        p_req[p] = 1'b0;
        break;
      end
      if (p_req[p] && !ack_p(p)) continue;
      if ((p == 0 ? cq0.size() : cq1.size()) != 0) begin
        if (p == 0) c = cq0.pop_front(); else c = cq1.pop_front();
        c.t = cyc;
        p_we[p] = c.we; p_addr[p] = c.addr; p_wdata[p] = c.wdata; p_req[p] = 1'b1;
        if (p == 0) ex0.push_back(c); else ex1.push_back(c);
      end else p_req[p] = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("expectations_drained", ex0.size() + ex1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int w0, r0, base;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack_err", {p0_ack, p1_ack, p0_err, p1_err}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    chk("rst_mem_ctl", {mem_rd, mem_wr, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_quiet", {p0_ack, p1_ack, p0_err, p1_err, mem_rd, mem_wr}, 0);
    chk("idle_no_strobes", wr_cnt + rd_cnt, 0);

    w0 = wr_cnt;
    push(0, 1, 16'h0010, 16'hBEEF, 0, 0, 2);
    run_port(0); drain();
    chk("w10_one_pulse", wr_cnt - w0, 1);
    chk("w10_mem", mem[8], 16'hBEEF);
    push(0, 0, 16'h0010, 0, 0, 16'hBEEF, 2);
    run_port(0); drain();

    rst_n = 1'b0;
    push(0, 0, 16'h0010, 0,       0, 16'hBEEF, 0);
    push(0, 0, 16'h0020, 0,       0, 16'h1234, 0);
    push(0, 1, 16'h0022, 16'h0101, 0, 0,       0);
    push(0, 0, 16'h0030, 0,       0, 16'h5555, 0);
    push(1, 1, 16'h0020, 16'h1234, 0, 0,       0);
    push(1, 1, 16'h0030, 16'h5555, 0, 0,       0);
    push(1, 0, 16'h0022, 0,       0, 16'h0101, 0);
    push(1, 0, 16'h0010, 0,       0, 16'hBEEF, 0);
    base = ack_log.size();
    fork
      run_port(0);
      run_port(1);
      begin
        repeat (3) begin
          @(negedge clk); #1;
          chk("rst_req_no_strobe", {mem_rd, mem_wr}, 0);
        end
        rst_n = 1'b1;
      end
    join
    drain();
    chk("grant_count", ack_log.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < ack_log.size()) chk($sformatf("grant_order_%0d", i), ack_log[base+i], i % 2);

    w0 = wr_cnt; r0 = rd_cnt;
    push(1, 0, 16'h0011, 0,       1, 0, 2);
    push(1, 0, 16'h0080, 0,       1, 0, 3);
    push(1, 1, 16'hFFFE, 16'h5A5A, 1, 0, 3);
    run_port(1); drain();
    chk("illegal_no_write", wr_cnt - w0, 0);
    chk("illegal_no_read", rd_cnt - r0, 0);

    push(0, 1, 16'h0004, 16'h7777, 0, 0, 2);
    run_port(0); drain();
    w0 = wr_cnt;
    @(negedge clk);
    p_we[0] = 1'b1; p_addr[0] = 16'h0004; p_wdata[0] = 16'hAAAA; p_req[0] = 1'b1;
    @(negedge clk);
    chk("midrst_in_access", mem_wr, 1);
    rst_n = 1'b0;
    p_req[0] = 1'b0;
    #2;
    chk("midrst_wr_gated", mem_wr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_write", wr_cnt - w0, 0);
    chk("midrst_mem_kept", mem[2], 16'h7777);
    push(0, 0, 16'h0004, 0, 0, 16'h7777, 2);
    run_port(0); drain();

    push(0, 0, 16'h0010, 0, 0, 16'hBEEF, 2);
    push(0, 0, 16'h0020, 0, 0, 16'h1234, 3);
    run_port(0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
